// File: rtl/biq_pkg.sv
// Shared types and constants for the branch info queue.
package biq_pkg;

    localparam int BIQ_DEPTH_DEFAULT = 8;
    localparam int PC_W              = 32;

    typedef struct packed {
        logic            valid;
        logic            resolved;
        logic            pred;
        logic            taken;
        logic [PC_W-1:0] pc;
    } biq_entry_t;

endpackage

// File: rtl/biq_ptr.sv
// Wrap-bit pointer register: the MSB toggles each time the index wraps.
module biq_ptr #(
    parameter int PTR_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inc,
    input  logic           clr,
    output logic [PTR_W:0] ptr
);

    logic [PTR_W:0] ptr_d;
    logic [PTR_W:0] ptr_q;

    // Next pointer: clear has priority over increment.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + {{PTR_W{1'b0}}, 1'b1};
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/branch_info_queue.sv
// In-order queue of in-flight branches feeding the predictor's training port.
// Optional BIQ_MISPRED_CNT_EN adds a saturating retired-mispredict counter.
module branch_info_queue
    import biq_pkg::*;
#(
    parameter  int DEPTH = BIQ_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_vld,
    input  logic [PC_W-1:0]  alloc_pc,
    input  logic             alloc_pred,
    output logic             alloc_rdy,
    output logic [PTR_W-1:0] alloc_tag,
    input  logic             res_vld,
    input  logic [PTR_W-1:0] res_tag,
    input  logic             res_taken,
    input  logic             commit_en,
    input  logic             flush,
    output logic [PC_W-1:0]  PC_retire,
    output logic             retire_en,
    output logic             jump_retire,
    output logic             mispred_retire,
`ifdef BIQ_MISPRED_CNT_EN
    output logic [31:0]      mispred_cnt,
`endif
    output logic             empty,
    output logic [PTR_W:0]   count
);

    biq_entry_t     entry_d [DEPTH];
    biq_entry_t     entry_q [DEPTH];
    logic [PTR_W:0] head_ptr;
    logic [PTR_W:0] tail_ptr;
    logic           full_s;
    logic           empty_s;
    logic           alloc_acc_s;
    logic           retire_acc_s;
    biq_entry_t     head_entry_s;

    logic [PC_W-1:0] pc_retire_d, pc_retire_q;
    logic            retire_en_d, retire_en_q;
    logic            jump_retire_d, jump_retire_q;
    logic            mispred_d, mispred_q;

    assign empty_s      = (head_ptr == tail_ptr);
    assign full_s       = (head_ptr[PTR_W-1:0] == tail_ptr[PTR_W-1:0]) &&
                          (head_ptr[PTR_W] != tail_ptr[PTR_W]);
    assign head_entry_s = entry_q[head_ptr[PTR_W-1:0]];
    // Retire looks only at registered state, so a same-cycle resolve cannot enable it.
    assign retire_acc_s = commit_en && !empty_s && head_entry_s.resolved;
    assign alloc_acc_s  = alloc_vld && !full_s && !flush;

    biq_ptr #(.PTR_W(PTR_W)) u_head (
        .clk (clk),
        .rst (rst),
        .inc (retire_acc_s),
        .clr (flush),
        .ptr (head_ptr)
    );

    biq_ptr #(.PTR_W(PTR_W)) u_tail (
        .clk (clk),
        .rst (rst),
        .inc (alloc_acc_s),
        .clr (flush),
        .ptr (tail_ptr)
    );

    // Entry update: flush wipes all; otherwise resolve, then retire invalidate, then alloc.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_q[i];
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i].valid    = 1'b0;
                entry_d[i].resolved = 1'b0;
            end
        end else begin
            if (res_vld && entry_q[res_tag].valid) begin
                entry_d[res_tag].resolved = 1'b1;
                entry_d[res_tag].taken    = res_taken;
            end else begin
                entry_d[res_tag] = entry_d[res_tag];
            end
            if (retire_acc_s) begin
                entry_d[head_ptr[PTR_W-1:0]].valid    = 1'b0;
                entry_d[head_ptr[PTR_W-1:0]].resolved = 1'b0;
            end else begin
                entry_d[head_ptr[PTR_W-1:0]] = entry_d[head_ptr[PTR_W-1:0]];
            end
            if (alloc_acc_s) begin
                entry_d[tail_ptr[PTR_W-1:0]] = '{valid: 1'b1, resolved: 1'b0,
                                                 pred: alloc_pred, taken: 1'b0,
                                                 pc: alloc_pc};
            end else begin
                entry_d[tail_ptr[PTR_W-1:0]] = entry_d[tail_ptr[PTR_W-1:0]];
            end
        end
    end

    // Retire output next-state; PC and direction hold between retires.
    always_comb begin
        retire_en_d   = retire_acc_s;
        pc_retire_d   = pc_retire_q;
        jump_retire_d = jump_retire_q;
        mispred_d     = 1'b0;
        if (retire_acc_s) begin
            pc_retire_d   = head_entry_s.pc;
            jump_retire_d = head_entry_s.taken;
            mispred_d     = head_entry_s.taken ^ head_entry_s.pred;
        end else begin
            mispred_d     = 1'b0;
        end
    end

    // Entry storage and retire output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            pc_retire_q   <= '0;
            retire_en_q   <= 1'b0;
            jump_retire_q <= 1'b0;
            mispred_q     <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            pc_retire_q   <= pc_retire_d;
            retire_en_q   <= retire_en_d;
            jump_retire_q <= jump_retire_d;
            mispred_q     <= mispred_d;
        end
    end

`ifdef BIQ_MISPRED_CNT_EN
    logic [31:0] mispred_cnt_d, mispred_cnt_q;

    // Saturating mispredict counter; deliberately untouched by flush.
    always_comb begin
        mispred_cnt_d = mispred_cnt_q;
        if (retire_en_q && mispred_q && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
            mispred_cnt_d = mispred_cnt_q + 32'd1;
        end else begin
            mispred_cnt_d = mispred_cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mispred_cnt_q <= 32'd0;
        end else begin
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign mispred_cnt = mispred_cnt_q;
`endif

    assign alloc_rdy      = !full_s;
    assign alloc_tag      = tail_ptr[PTR_W-1:0];
    assign empty          = empty_s;
    assign count          = tail_ptr - head_ptr;
    assign PC_retire      = pc_retire_q;
    assign retire_en      = retire_en_q;
    assign jump_retire    = jump_retire_q;
    assign mispred_retire = mispred_q;

endmodule

// File: tb/tb_branch_info_queue.sv
// Directed self-checking bench for branch_info_queue (DEPTH = 8).
// Define BIQ_MISPRED_CNT_EN to also exercise the mispredict counter.
module tb_branch_info_queue;

    logic        clk;
    logic        rst;
    logic        alloc_vld;
    logic [31:0] alloc_pc;
    logic        alloc_pred;
    logic        alloc_rdy;
    logic [2:0]  alloc_tag;
    logic        res_vld;
    logic [2:0]  res_tag;
    logic        res_taken;
    logic        commit_en;
    logic        flush;
    logic [31:0] PC_retire;
    logic        retire_en;
    logic        jump_retire;
    logic        mispred_retire;
    logic        empty;
    logic [3:0]  count;
`ifdef BIQ_MISPRED_CNT_EN
    logic [31:0] mispred_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    branch_info_queue #(.DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_vld      (alloc_vld),
        .alloc_pc       (alloc_pc),
        .alloc_pred     (alloc_pred),
        .alloc_rdy      (alloc_rdy),
        .alloc_tag      (alloc_tag),
        .res_vld        (res_vld),
        .res_tag        (res_tag),
        .res_taken      (res_taken),
        .commit_en      (commit_en),
        .flush          (flush),
        .PC_retire      (PC_retire),
        .retire_en      (retire_en),
        .jump_retire    (jump_retire),
        .mispred_retire (mispred_retire),
`ifdef BIQ_MISPRED_CNT_EN
        .mispred_cnt    (mispred_cnt),
`endif
        .empty          (empty),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        alloc_vld = 1'b0;
        res_vld   = 1'b0;
        commit_en = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_alloc(input logic [31:0] pc, input logic pred);
        alloc_vld  = 1'b1;
        alloc_pc   = pc;
        alloc_pred = pred;
        tick();
    endtask

    task automatic do_resolve(input logic [2:0] tag, input logic taken);
        res_vld   = 1'b1;
        res_tag   = tag;
        res_taken = taken;
        tick();
    endtask

    task automatic do_commit();
        commit_en = 1'b1;
        tick();
    endtask

    initial begin
        rst = 1'b1; alloc_vld = 1'b0; alloc_pc = 32'h0; alloc_pred = 1'b0;
        res_vld = 1'b0; res_tag = 3'd0; res_taken = 1'b0; commit_en = 1'b0; flush = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // 1: reset state and first allocation
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_rdy", {31'd0, alloc_rdy}, 32'd1);
        check("rst_retire_en", {31'd0, retire_en}, 32'd0);
        check("rst_pc_retire", PC_retire, 32'd0);
        check("first_tag", {29'd0, alloc_tag}, 32'd0);
        do_alloc(32'h1C00_0010, 1'b1);
        check("first_count", {28'd0, count}, 32'd1);
        check("first_empty", {31'd0, empty}, 32'd0);

        // 2: fill, overflow drop, retire and wrap
        for (int i = 1; i < 8; i++) begin
            check("fill_tag", {29'd0, alloc_tag}, i);
            do_alloc(32'h0000_0100 + 32'(i * 4), 1'b0);
        end
        check("full_count", {28'd0, count}, 32'd8);
        check("full_rdy", {31'd0, alloc_rdy}, 32'd0);
        do_alloc(32'hDEAD_BEEF, 1'b0);
        check("ovf_count", {28'd0, count}, 32'd8);
        check("ovf_tag", {29'd0, alloc_tag}, 32'd0);
        do_resolve(3'd0, 1'b1);
        do_commit();
        check("wrap_retire_en", {31'd0, retire_en}, 32'd1);
        check("wrap_pc", PC_retire, 32'h1C00_0010);
        check("wrap_jump", {31'd0, jump_retire}, 32'd1);
        check("wrap_mispred", {31'd0, mispred_retire}, 32'd0);
        check("wrap_count", {28'd0, count}, 32'd7);
        check("wrap_rdy", {31'd0, alloc_rdy}, 32'd1);
        check("wrap_tag", {29'd0, alloc_tag}, 32'd0);
        do_alloc(32'h0000_0200, 1'b0);
        check("refill_count", {28'd0, count}, 32'd8);
        check("pulse_len", {31'd0, retire_en}, 32'd0);
        check("pc_hold", PC_retire, 32'h1C00_0010);
        flush = 1'b1;
        tick();
        check("flush1_count", {28'd0, count}, 32'd0);
        check("flush1_tag", {29'd0, alloc_tag}, 32'd0);

        // 3: out-of-order resolve, in-order retire, mispredict
        do_alloc(32'h0000_2000, 1'b1);
        do_alloc(32'h0000_2004, 1'b0);
        do_resolve(3'd1, 1'b1);
        do_commit();
        check("blocked_retire", {31'd0, retire_en}, 32'd0);
        check("blocked_count", {28'd0, count}, 32'd2);
        do_resolve(3'd0, 1'b0);
        do_commit();
        check("mp_retire_en", {31'd0, retire_en}, 32'd1);
        check("mp_jump", {31'd0, jump_retire}, 32'd0);
        check("mp_mispred", {31'd0, mispred_retire}, 32'd1);
        check("mp_pc", PC_retire, 32'h0000_2000);
        check("mp_count", {28'd0, count}, 32'd1);
        tick();
        check("mp_clear", {31'd0, mispred_retire}, 32'd0);

        // 4: same-cycle resolve + commit does not retire
        do_commit();
        check("b_pc", PC_retire, 32'h0000_2004);
        check("b_mispred", {31'd0, mispred_retire}, 32'd1);
        check("b_empty", {31'd0, empty}, 32'd1);
        do_alloc(32'h0000_3000, 1'b0);
        res_vld = 1'b1; res_tag = 3'd2; res_taken = 1'b0; commit_en = 1'b1;
        tick();
        check("same_cyc_retire", {31'd0, retire_en}, 32'd0);
        check("same_cyc_count", {28'd0, count}, 32'd1);
        do_commit();
        check("late_retire", {31'd0, retire_en}, 32'd1);
        check("late_pc", PC_retire, 32'h0000_3000);
        check("late_mispred", {31'd0, mispred_retire}, 32'd0);
        do_commit();
        check("empty_commit", {31'd0, retire_en}, 32'd0);
        check("empty_count", {28'd0, count}, 32'd0);

        // 5: flush overrides alloc and resolve
        do_alloc(32'h0000_4000, 1'b1);
        do_alloc(32'h0000_4004, 1'b1);
        do_alloc(32'h0000_4008, 1'b1);
        check("pre_flush_count", {28'd0, count}, 32'd3);
        flush = 1'b1; alloc_vld = 1'b1; alloc_pc = 32'h0000_5555;
        res_vld = 1'b1; res_tag = 3'd3; res_taken = 1'b0;
        tick();
        check("flush_count", {28'd0, count}, 32'd0);
        check("flush_empty", {31'd0, empty}, 32'd1);
        check("flush_rdy", {31'd0, alloc_rdy}, 32'd1);
        do_resolve(3'd0, 1'b1);
        do_alloc(32'h0000_6000, 1'b1);
        do_commit();
        check("stale_res_ignored", {31'd0, retire_en}, 32'd0);
        do_resolve(3'd0, 1'b1);
        do_commit();
        check("post_flush_retire", {31'd0, retire_en}, 32'd1);
        check("post_flush_pc", PC_retire, 32'h0000_6000);

        // mid-operation reset drops the pending pulse
        rst = 1'b1;
        #1;
        check("async_rst_retire", {31'd0, retire_en}, 32'd0);
        check("async_rst_pc", PC_retire, 32'd0);
        tick();
        rst = 1'b0;
        check("async_rst_empty", {31'd0, empty}, 32'd1);

`ifdef BIQ_MISPRED_CNT_EN
        // 6: mispredict counter
        check("cnt_reset", mispred_cnt, 32'd0);
        for (int i = 0; i < 5; i++) begin
            do_alloc(32'h0000_7000 + 32'(i * 4), 1'b1);
        end
        for (int i = 0; i < 5; i++) begin
            do_resolve(3'(i), (i >= 3) ? 1'b1 : 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            do_commit();
        end
        tick();
        tick();
        check("cnt_value", mispred_cnt, 32'd3);
        flush = 1'b1;
        tick();
        tick();
        check("cnt_after_flush", mispred_cnt, 32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
